// File: rtl/flush_seq_unit.sv
// rtl/flush_seq_unit.sv - sequencer for MSHR clears, TLB flush and L1D-to-L2C sync.
// Optional watchdog enabled by macro FLUSH_SEQ_TIMEOUT_EN.
module flush_seq_unit #(
  parameter int ASID_W         = 16,
  parameter int VPN_W          = 27,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_flush_type_i,
  input  logic [ASID_W-1:0] req_asid_i,
  input  logic [VPN_W-1:0]  req_vpn_i,
  input  logic              req_clr_tlb_mshr_i,
  input  logic              req_clr_dmshr_i,
  input  logic              req_sync_i,
  output logic              tlb_clr_mshr_o,
  output logic              dmshr_clr_o,
  output logic              tlb_flush_valid_o,
  output logic [1:0]        tlb_flush_type_o,
  output logic [ASID_W-1:0] tlb_flush_asid_o,
  output logic [VPN_W-1:0]  tlb_flush_vpn_o,
  input  logic              tlb_flush_ack_i,
  output logic              sync_req_o,
  input  logic              l2c_update_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_TLB, S_SYNC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ftype_q, ftype_d;
  logic [ASID_W-1:0] asid_q, asid_d;
  logic [VPN_W-1:0]  vpn_q, vpn_d;
  logic              clr_tlb_q, clr_tlb_d;
  logic              clr_dm_q, clr_dm_d;
  logic              sync_q, sync_d;
  logic              ready_c;
  logic              timeout;

  always_comb begin
    state_d           = state_q;
    ftype_d           = ftype_q;
    asid_d            = asid_q;
    vpn_d             = vpn_q;
    clr_tlb_d         = clr_tlb_q;
    clr_dm_d          = clr_dm_q;
    sync_d            = sync_q;
    ready_c           = 1'b0;
    tlb_clr_mshr_o    = 1'b0;
    dmshr_clr_o       = 1'b0;
    tlb_flush_valid_o = 1'b0;
    sync_req_o        = 1'b0;
    done_o            = 1'b0;
    busy_o            = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (req_valid_i) begin
          ftype_d   = req_flush_type_i;
          asid_d    = req_asid_i;
          vpn_d     = req_vpn_i;
          clr_tlb_d = req_clr_tlb_mshr_i;
          clr_dm_d  = req_clr_dmshr_i;
          sync_d    = req_sync_i;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tlb_clr_mshr_o = clr_tlb_q;
        dmshr_clr_o    = clr_dm_q;
        if (ftype_q != 2'd0) state_d = S_TLB;
        else if (sync_q)     state_d = S_SYNC;
        else                 state_d = S_DONE;
      end
      S_TLB: begin
        tlb_flush_valid_o = 1'b1;
        if (tlb_flush_ack_i) state_d = sync_q ? S_SYNC : S_DONE;
        else if (timeout)    state_d = S_DONE;
      end
      S_SYNC: begin
        sync_req_o = 1'b1;
        if (l2c_update_done_i || timeout) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign req_ready_o      = ready_c & rst_n_i;
  assign tlb_flush_type_o = ftype_q;
  assign tlb_flush_asid_o = asid_q;
  assign tlb_flush_vpn_o  = vpn_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      ftype_q   <= '0;
      asid_q    <= '0;
      vpn_q     <= '0;
      clr_tlb_q <= 1'b0;
      clr_dm_q  <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ftype_q   <= ftype_d;
      asid_q    <= asid_d;
      vpn_q     <= vpn_d;
      clr_tlb_q <= clr_tlb_d;
      clr_dm_q  <= clr_dm_d;
      sync_q    <= sync_d;
    end
  end

`ifdef FLUSH_SEQ_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Fires on the last allowed waiting cycle so the strobe is high exactly TIMEOUT_CYCLES cycles.
  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if ((state_q == S_TLB || state_q == S_SYNC) && state_d == state_q)
      cnt_d = cnt_q + CNT_W'(1);
    if (state_q == S_IDLE && req_valid_i)
      err_d = 1'b0;
    if ((state_q == S_TLB && !tlb_flush_ack_i && timeout) ||
        (state_q == S_SYNC && !l2c_update_done_i && timeout))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q & (state_q == S_DONE);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_flush_seq_unit.sv
// tb/tb_flush_seq_unit.sv - randomized self-checking bench for flush_seq_unit.
// Exercises the FLUSH_SEQ_TIMEOUT_EN watchdog when that macro is defined.
module tb_flush_seq_unit;

  localparam int T = 8;
`ifdef FLUSH_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_CLEAR = 1, P_TLB = 2, P_SYNC = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = '0;
  logic [15:0] req_asid = '0;
  logic [26:0] req_vpn = '0;
  logic        req_ct = 1'b0, req_cd = 1'b0, req_sy = 1'b0;
  logic        clr_tlb, clr_dm, fl_valid, sync_req, busy, done, err;
  logic [1:0]  fl_type;
  logic [15:0] fl_asid;
  logic [26:0] fl_vpn;
  logic        ack = 1'b0, l2c = 1'b0;

  int checks = 0;
  int errors = 0;

  flush_seq_unit #(.ASID_W(16), .VPN_W(27), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_flush_type_i(req_type), .req_asid_i(req_asid), .req_vpn_i(req_vpn),
    .req_clr_tlb_mshr_i(req_ct), .req_clr_dmshr_i(req_cd), .req_sync_i(req_sy),
    .tlb_clr_mshr_o(clr_tlb), .dmshr_clr_o(clr_dm),
    .tlb_flush_valid_o(fl_valid), .tlb_flush_type_o(fl_type),
    .tlb_flush_asid_o(fl_asid), .tlb_flush_vpn_o(fl_vpn),
    .tlb_flush_ack_i(ack), .sync_req_o(sync_req), .l2c_update_done_i(l2c),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {req_ready, busy, clr_tlb, clr_dm, fl_valid, sync_req, done, err};
  endfunction

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // Model: a request is a list of phases; each phase fixes the expected strobe pattern.
  task automatic run_req(input string name, input logic [1:0] ft, input logic [15:0] asid,
                         input logic [26:0] vpn, input logic ct, input logic cd, input logic sy,
                         input int a, input int d, input bit noise, input bit hold);
    int ph[$];
    int tlb_n, syn_n, sync_start, p;
    bit timed;
    logic [7:0] exp_v, got;
    timed = 1'b0;
    ph.push_back(P_CLEAR);
    if (ft != 2'd0) begin
      tlb_n = a + 1;
      if (TO_EN && tlb_n > T) begin tlb_n = T; timed = 1'b1; end
      for (int k = 0; k < tlb_n; k++) ph.push_back(P_TLB);
    end
    sync_start = ph.size() + 1;
    if (sy && !timed) begin
      syn_n = d + 1;
      if (TO_EN && syn_n > T) begin syn_n = T; timed = 1'b1; end
      for (int k = 0; k < syn_n; k++) ph.push_back(P_SYNC);
    end
    ph.push_back(P_DONE);
    ph.push_back(P_IDLE);

    @(posedge clk); #1;
    req_valid = 1'b1; req_type = ft; req_asid = asid; req_vpn = vpn;
    req_ct = ct; req_cd = cd; req_sy = sy;
    ack = noise ? rbit() : 1'b0;
    l2c = noise ? rbit() : 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 8'b1000_0000) begin
      errors++;
      $display("FAIL %s pre-accept got=%b exp=%b", name, outs(), 8'b1000_0000);
    end

    for (int i = 1; i <= ph.size(); i++) begin
      @(posedge clk); #1;
      p = ph[i-1];
      if (!hold || p == P_IDLE) req_valid = 1'b0;
      if (hold) begin
        req_type = 2'($urandom); req_asid = 16'($urandom); req_vpn = 27'($urandom);
      end
      ack = (p == P_TLB)  ? (i == 2 + a)          : (noise ? rbit() : 1'b0);
      l2c = (p == P_SYNC) ? (i == sync_start + d) : (noise ? rbit() : 1'b0);
      @(negedge clk);
      case (p)
        P_CLEAR: exp_v = {2'b01, ct, cd, 4'b0000};
        P_TLB:   exp_v = 8'b0100_1000;
        P_SYNC:  exp_v = 8'b0100_0100;
        P_DONE:  exp_v = {7'b0100_001, timed};
        default: exp_v = 8'b1000_0000;
      endcase
      got = outs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s strobes cyc%0d got=%b exp=%b", name, i, got, exp_v);
      end
      checks++;
      if ({fl_type, fl_asid, fl_vpn} !== {ft, asid, vpn}) begin
        errors++;
        $display("FAIL %s fields cyc%0d got=%h/%h/%h exp=%h/%h/%h", name, i,
                 fl_type, fl_asid, fl_vpn, ft, asid, vpn);
      end
    end
    ack = 1'b0; l2c = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({outs(), fl_type, fl_asid, fl_vpn} !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%b fields=%h/%h/%h exp=0", outs(), fl_type, fl_asid, fl_vpn);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", outs(), 8'b1000_0000);
    end
  endtask

  task automatic test_empty();
    run_req("empty", 2'd0, 16'h0, 27'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_clears();
    run_req("clears", 2'd0, 16'h0, 27'h0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_asid_sync();
    run_req("asid_sync", 2'd2, 16'h005A, 27'h0, 1'b0, 1'b0, 1'b1, 3, 5, 1'b0, 1'b0);
  endtask

  task automatic test_page_noise();
    run_req("page_noise", 2'd3, 16'h1234, 27'h1234567, 1'b1, 1'b0, 1'b1, 2, 1, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    req_valid = 1'b1; req_type = 2'd0; req_sy = 1'b1; req_ct = 1'b0; req_cd = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (sync_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_in_sync got=%b exp=1", sync_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset_async got=%b exp=%b", outs(), 8'b0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 8'b1000_0000) begin
        errors++;
        $display("FAIL mid_reset_after cyc%0d got=%b exp=%b", i, outs(), 8'b1000_0000);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_req("random", 2'($urandom), 16'($urandom), 27'($urandom), rbit(), rbit(), rbit(),
              $urandom_range(0, 10), $urandom_range(0, 10), bit'(rbit()), bit'(rbit()));
  endtask

  task automatic test_timeout();
    run_req("timeout_tlb", 2'd1, 16'h00FF, 27'h0, 1'b0, 1'b0, 1'b1, 20, 0, 1'b0, 1'b0);
    run_req("timeout_sync", 2'd0, 16'h0, 27'h0, 1'b1, 1'b0, 1'b1, 0, 15, 1'b1, 1'b0);
    run_req("edge_tlb", 2'd2, 16'h0001, 27'h0, 1'b0, 1'b0, 1'b1, T - 1, T - 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_clears();
    test_asid_sync();
    test_page_noise();
    test_mid_reset();
    test_random();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_req("back_to_back", 2'd1, 16'($urandom), 27'($urandom), 1'b1, 1'b1, 1'b1,
              0, 0, 1'b1, 1'b1);
  endtask

endmodule

// File: doc/flush_seq_unit.md
# flush_seq_unit

Memory-side sequencer that executes the maintenance requests issued by the pipeline control unit: TLB/data-MSHR clears, L1/L2 TLB flushes, and L1D-to-L2 cache synchronisation. It sits between the control unit and the memory subsystem (TLBs, L1D MSHRs, L2C). It accepts one request over a valid/ready handshake and runs the required sub-operations in a fixed order. It holds `busy_o` high for the control unit's stall logic and pulses `done_o` on completion.

## Interface
- `ASID_W`, default 16: ASID width.
- `VPN_W`, default 27: virtual page number width (SV39).
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only under the macro in Configuration.

Ports:
- `clk_i`  in  1  clock. Single clock domain.
- `rst_n_i`  in  1  reset. **Asynchronous, active-low.**
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i` and `req_ready_o` are both high at a rising edge.
- `req_flush_type_i`  in  2  TLB flush type: 0 NoFlush, 1 FlushAll, 2 FlushASID, 3 FlushPage.
- `req_asid_i`  in  ASID_W  ASID for FlushASID and FlushPage.
- `req_vpn_i`  in  VPN_W  page for FlushPage.
- `req_clr_tlb_mshr_i`  in  1  clear L1/L2 TLB MSHRs.
- `req_clr_dmshr_i`  in  1  clear D-cache MSHRs and data registers.
- `req_sync_i`  in  1  synchronise L1D with L2C.
- `tlb_clr_mshr_o`  out  1  one-cycle clear pulse to L1TLB and L2TLB.
- `dmshr_clr_o`  out  1  one-cycle clear pulse to the L1D MSHRs.
- `tlb_flush_valid_o`  out  1  TLB flush command valid.
- `tlb_flush_type_o`  out  2  latched flush type.
- `tlb_flush_asid_o`  out  ASID_W  latched ASID.
- `tlb_flush_vpn_o`  out  VPN_W  latched VPN.
- `tlb_flush_ack_i`  in  1  TLB flush complete.
- `sync_req_o`  out  1  level request for an L1D-to-L2C writeback.
- `l2c_update_done_i`  in  1  L2C update finished.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  timeout indication, valid with `done_o`.

## Operation
- States: IDLE, CLEAR, TLB, SYNC, DONE.
- **IDLE**
  - `req_ready_o`=1.
  - On accept, latch all `req_*` fields and go to CLEAR.
- **CLEAR** (exactly one cycle)
  - `tlb_clr_mshr_o` = latched clr_tlb_mshr.
  - `dmshr_clr_o` = latched clr_dmshr.
  - Next state: TLB if the latched flush type ≠ 0; else SYNC if the latched sync bit is set; else DONE.
- **TLB**
  - `tlb_flush_valid_o`=1; type/asid/vpn driven from the latched values.
  - Leave when `tlb_flush_ack_i`=1 in the same cycle.
  - Next state: SYNC if the latched sync bit is set, else DONE.
- **SYNC**
  - `sync_req_o`=1.
  - Leave to DONE when `l2c_update_done_i`=1.
- **DONE**: `done_o`=1 for one cycle, then IDLE.
- Order is fixed: MSHR clears before TLB flush, TLB flush before sync.
- `tlb_flush_ack_i` and `l2c_update_done_i` are ignored outside TLB and SYNC respectively.
- An all-zero request is legal and takes the path CLEAR → DONE.
- Flush fields on the outputs hold the latched values in every state. Their value outside TLB is don't-care, but it must be stable.

## Timing
- Reset values: all outputs 0, state IDLE, latched fields 0. Exception: `req_ready_o`=1 once reset is released.
- Reset mid-operation: the request is discarded, strobes drop immediately (asynchronously), and nothing resumes.
- Minimum latency for an empty request:
  - accept edge N;
  - CLEAR in cycle N+1;
  - DONE (`done_o`=1) in cycle N+2;
  - `req_ready_o`=1 from cycle N+3.
- Full request with same-cycle ack/done: CLEAR, TLB, SYNC and DONE each take one cycle, so `done_o` appears 4 cycles after accept.
- `req_ready_o` is low from the cycle after accept through DONE inclusive. A request held valid is not re-accepted in DONE.
- `busy_o` rises the cycle after accept.
- No combinational path from `req_valid_i` to any output other than through state.

## Configuration
- Macro: `FLUSH_SEQ_TIMEOUT_EN`.
- **Defined**
  - A counter of width clog2(TIMEOUT_CYCLES+1) resets on entry to TLB or SYNC and increments each cycle spent waiting there.
  - When it reaches TIMEOUT_CYCLES, the unit drops `tlb_flush_valid_o`/`sync_req_o` and goes directly to DONE with `err_o`=1 alongside `done_o`.
  - The remaining sub-operations (e.g. SYNC after a TLB timeout) are skipped.
- **Undefined**
  - No counter; the unit waits indefinitely.
  - `err_o` is tied to 0.

## Test plan
- Reset, then req flush=0, all clear bits 0 -> `done_o` at accept+2, no strobes, `busy_o` high for 2 cycles.
- Req clr_tlb_mshr=1, clr_dmshr=1, flush=0, sync=0 -> single-cycle pulse on both clear outputs at accept+1, `done_o` at accept+2.
- Req flush=2, asid=0x5A, sync=1, ack after 3 cycles, l2c done after 5 -> valid held exactly until ack with asid 0x5A, `sync_req_o` held until done, strict ordering, `done_o` once.
- Flush=3 with VPN=0x1234567; ack and a spurious `l2c_update_done_i` pulse arrive early in IDLE/CLEAR -> early pulses ignored, valid waits for an ack in TLB.
- Assert `rst_n_i` low while in SYNC -> `sync_req_o` falls immediately; after release the unit is in IDLE with `req_ready_o`=1 and no `done_o`.
- With `FLUSH_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=8, flush=1 and no ack -> valid drops after 8 waiting cycles, `done_o`=1 with `err_o`=1, and SYNC is skipped.
